// File: rtl/hub75_pkg.sv
// Shared panel geometry, scan FSM states and the bit-plane select helper
// for the HUB75 scan-out engine.
package hub75_pkg;

   localparam int unsigned PANEL_COLS      = 64;
   localparam int unsigned PANEL_SCAN_ROWS = 16;
   localparam int unsigned MAX_BPP         = 48;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StLatch,
      StDisplay
   } state_e;

   // Returns {R,G,B} bit 'plane' of a {R,G,B} pixel word with cb bits per channel.
   function automatic logic [2:0] plane_rgb(input logic [MAX_BPP-1:0] word,
                                            input int unsigned       cb,
                                            input int unsigned       plane);
      logic [2:0] bits;
      bits[2] = |((word >> (2 * cb + plane)) & MAX_BPP'(1));
      bits[1] = |((word >> (cb + plane)) & MAX_BPP'(1));
      bits[0] = |((word >> plane) & MAX_BPP'(1));
      return bits;
   endfunction

endpackage

// File: rtl/hub75_scanout.sv
// HUB75 scan-out: reads the panel pixel RAM row by row and shifts one bit-plane per pass,
// then latches and lights it for ON_CYCLES<<plane clocks (binary-coded modulation).
module hub75_scanout
   import hub75_pkg::*;
#(
   parameter int unsigned BITS_PER_PIXEL = 12,
   parameter int unsigned ON_CYCLES      = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable,
   output logic [9:0]                read_addr,
   output logic                      read_en,
   input  logic [BITS_PER_PIXEL-1:0] read_data_top,
   input  logic [BITS_PER_PIXEL-1:0] read_data_bottom,
   output logic                      hub75_r1,
   output logic                      hub75_g1,
   output logic                      hub75_b1,
   output logic                      hub75_r2,
   output logic                      hub75_g2,
   output logic                      hub75_b2,
   output logic                      hub75_clk,
   output logic                      hub75_lat,
   output logic                      hub75_oe_n,
   output logic [3:0]                hub75_addr,
   output logic                      frame_done
);

   localparam int unsigned CB     = BITS_PER_PIXEL / 3;
   localparam int unsigned PW     = (CB > 1) ? $clog2(CB) : 1;
   localparam int unsigned ON_MAX = ON_CYCLES << (CB - 1);
   localparam int unsigned OW     = $clog2(ON_MAX + 1);

   localparam logic [5:0]    LAST_COL   = 6'(PANEL_COLS - 1);
   localparam logic [3:0]    LAST_ROW   = 4'(PANEL_SCAN_ROWS - 1);
   localparam logic [PW-1:0] LAST_PLANE = PW'(CB - 1);

   state_e        state_q, state_d;
   logic [3:0]    row_q, row_d;
   logic [PW-1:0] plane_q, plane_d;
   logic [5:0]    col_q, col_d;
   logic          phase_q, phase_d;
   logic [OW-1:0] on_cnt_q, on_cnt_d;
   logic [OW-1:0] on_last;

   // Every panel/RAM output is registered; *_d is what it holds in the next state.
   logic [9:0] raddr_q, raddr_d;
   logic       ren_q, ren_d;
   logic [5:0] rgb_q, rgb_d;
   logic       hclk_q, hclk_d;
   logic       lat_q, lat_d;
   logic       oe_n_q, oe_n_d;
   logic [3:0] haddr_q, haddr_d;
   logic       fd_q, fd_d;

   assign on_last = (OW'(ON_CYCLES) << plane_q) - OW'(1);

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      plane_d  = plane_q;
      col_d    = col_q;
      phase_d  = phase_q;
      on_cnt_d = on_cnt_q;
      raddr_d  = raddr_q;
      ren_d    = ren_q;
      rgb_d    = rgb_q;
      hclk_d   = hclk_q;
      lat_d    = lat_q;
      oe_n_d   = oe_n_q;
      haddr_d  = haddr_q;
      fd_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            state_d = StShift;
            col_d   = '0;
            phase_d = 1'b0;
         end
         StShift: begin
            if (!phase_q) begin
               // Data for col_q was addressed two edges ago; prefetch the next column.
               phase_d = 1'b1;
               hclk_d  = 1'b1;
               rgb_d   = {plane_rgb(MAX_BPP'(read_data_top), CB, 32'(plane_q)),
                          plane_rgb(MAX_BPP'(read_data_bottom), CB, 32'(plane_q))};
               raddr_d = {row_q, col_q + 6'd1};
            end else begin
               phase_d = 1'b0;
               hclk_d  = 1'b0;
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = StLatch;
                  lat_d   = 1'b1;
                  oe_n_d  = 1'b1;
                  ren_d   = 1'b0;
                  haddr_d = row_q;
               end else begin
                  col_d = col_q + 6'd1;
               end
            end
         end
         StLatch: begin
            state_d  = StDisplay;
            lat_d    = 1'b0;
            oe_n_d   = 1'b0;
            on_cnt_d = '0;
         end
         StDisplay: begin
            if (on_cnt_q == on_last) begin
               oe_n_d = 1'b1;
               if (plane_q == LAST_PLANE) begin
                  plane_d = '0;
                  row_d   = row_q + 4'd1;
                  if (row_q == LAST_ROW) begin
                     fd_d    = 1'b1;
                     state_d = enable ? StLoad : StIdle;
                  end else begin
                     state_d = StLoad;
                  end
               end else begin
                  plane_d = plane_q + PW'(1);
                  state_d = StLoad;
               end
            end else begin
               on_cnt_d = on_cnt_q + OW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Entering LOAD always addresses column 0 of the (possibly just advanced) row.
      if (state_d == StLoad) begin
         raddr_d = {row_d, 6'd0};
         ren_d   = 1'b1;
         hclk_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         row_q    <= '0;
         plane_q  <= '0;
         col_q    <= '0;
         phase_q  <= 1'b0;
         on_cnt_q <= '0;
         raddr_q  <= '0;
         ren_q    <= 1'b0;
         rgb_q    <= '0;
         hclk_q   <= 1'b0;
         lat_q    <= 1'b0;
         oe_n_q   <= 1'b1;
         haddr_q  <= '0;
         fd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         plane_q  <= plane_d;
         col_q    <= col_d;
         phase_q  <= phase_d;
         on_cnt_q <= on_cnt_d;
         raddr_q  <= raddr_d;
         ren_q    <= ren_d;
         rgb_q    <= rgb_d;
         hclk_q   <= hclk_d;
         lat_q    <= lat_d;
         oe_n_q   <= oe_n_d;
         haddr_q  <= haddr_d;
         fd_q     <= fd_d;
      end
   end

   assign read_addr  = raddr_q;
   assign read_en    = ren_q;
   assign hub75_r1   = rgb_q[5];
   assign hub75_g1   = rgb_q[4];
   assign hub75_b1   = rgb_q[3];
   assign hub75_r2   = rgb_q[2];
   assign hub75_g2   = rgb_q[1];
   assign hub75_b2   = rgb_q[0];
   assign hub75_clk  = hclk_q;
   assign hub75_lat  = lat_q;
   assign hub75_oe_n = oe_n_q;
   assign hub75_addr = haddr_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_hub75_scanout.sv
// Bench for hub75_scanout: RAM model plus a frame-position reference model checked every cycle,
// with directed literal checks on timing, bit-plane extraction, column order and reset.
module tb_hub75_scanout;

   localparam int ON         = 8;
   localparam int ROW_CLKS   = 640;
   localparam int FRAME_CLKS = 10240;
   localparam logic [24:0] RESET_VEC = 25'h20;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [9:0]  read_addr;
   logic        read_en;
   logic [11:0] rd_top, rd_bot;
   logic        hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2;
   logic        hub75_clk, hub75_lat, hub75_oe_n, frame_done;
   logic [3:0]  hub75_addr;

   logic [11:0] mem_top [1024];
   logic [11:0] mem_bot [1024];

   int checks   = 0;
   int failures = 0;

   // Reference model state: position within the frame and values the panel holds.
   bit         m_running = 1'b0;
   int         m_tick    = 0;
   logic       m_fd      = 1'b0;
   logic [9:0] m_raddr   = '0;
   logic [5:0] m_rgb     = '0;
   logic [3:0] m_haddr   = '0;

   logic [5:0] cap [4][64];
   int         cap_rises [4];

   always #5 clk = ~clk;

   hub75_scanout #(.BITS_PER_PIXEL(12), .ON_CYCLES(ON)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .enable           (enable),
      .read_addr        (read_addr),
      .read_en          (read_en),
      .read_data_top    (rd_top),
      .read_data_bottom (rd_bot),
      .hub75_r1         (hub75_r1),
      .hub75_g1         (hub75_g1),
      .hub75_b1         (hub75_b1),
      .hub75_r2         (hub75_r2),
      .hub75_g2         (hub75_g2),
      .hub75_b2         (hub75_b2),
      .hub75_clk        (hub75_clk),
      .hub75_lat        (hub75_lat),
      .hub75_oe_n       (hub75_oe_n),
      .hub75_addr       (hub75_addr),
      .frame_done       (frame_done)
   );

   // sync_pdp_ram read port: registered, all-ones while read_en is low.
   always @(posedge clk) begin
      if (read_en) begin
         rd_top <= mem_top[read_addr];
         rd_bot <= mem_bot[read_addr];
      end else begin
         rd_top <= '1;
         rd_bot <= '1;
      end
   end

   function automatic logic [2:0] bits3(input logic [11:0] w, input int p);
      logic [11:0] s;
      s = w >> p;
      return {s[8], s[4], s[0]};
   endfunction

   function automatic logic [24:0] outs();
      return {read_addr, read_en, hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2,
              hub75_clk, hub75_lat, hub75_oe_n, hub75_addr, frame_done};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (!reset_n) begin
         m_running = 1'b0;
         m_fd      = 1'b0;
         m_raddr   = '0;
         m_rgb     = '0;
         m_haddr   = '0;
      end else if (m_running) begin
         m_tick++;
         if (m_tick == FRAME_CLKS) begin
            m_fd      = 1'b1;
            m_tick    = 0;
            m_running = enable;
         end else begin
            m_fd = 1'b0;
         end
      end else begin
         m_fd = 1'b0;
         if (enable) begin
            m_running = 1'b1;
            m_tick    = 0;
         end
      end
   endtask

   task automatic model_check();
      logic [24:0] exp, act;
      logic        e_ren, e_hclk, e_lat, e_oe;
      int          r, w, p, k, c;
      act = outs();
      if (!reset_n) begin
         m_raddr = '0;
         m_rgb   = '0;
         m_haddr = '0;
         exp     = RESET_VEC;
      end else begin
         e_ren  = 1'b0;
         e_hclk = 1'b0;
         e_lat  = 1'b0;
         e_oe   = 1'b1;
         if (m_running) begin
            r = m_tick / ROW_CLKS;
            w = m_tick % ROW_CLKS;
            p = 0;
            while (w >= 130 + (ON << p)) begin
               w -= 130 + (ON << p);
               p++;
            end
            if (w == 0) begin
               m_raddr = {r[3:0], 6'd0};
               e_ren   = 1'b1;
            end else if (w <= 128) begin
               k     = w - 1;
               c     = k / 2;
               e_ren = 1'b1;
               if (k % 2 == 0) begin
                  m_raddr = {r[3:0], c[5:0]};
               end else begin
                  m_raddr = {r[3:0], 6'(c + 1)};
                  e_hclk  = 1'b1;
                  m_rgb   = {bits3(mem_top[r * 64 + c], p), bits3(mem_bot[r * 64 + c], p)};
               end
            end else if (w == 129) begin
               m_raddr = {r[3:0], 6'd0};
               e_lat   = 1'b1;
               m_haddr = r[3:0];
            end else begin
               m_raddr = {r[3:0], 6'd0};
               e_oe    = 1'b0;
            end
         end
         exp = {m_raddr, e_ren, m_rgb, e_hclk, e_lat, e_oe, m_haddr, m_fd};
      end
      if (failures < 40) begin
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL model_cycle t=%0t: got %h, expected %h", $time, act, exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_check();
   endtask

   task automatic wait_frame_done(input string name);
      int n;
      n = 0;
      while (!frame_done && n < 11000) begin
         tick();
         n++;
      end
      check(name, frame_done, 1);
   endtask

   task automatic capture(input int npass);
      logic [5:0] cur [64];
      int   rises, pidx, guard;
      logic ph, pl;
      for (int c = 0; c < 64; c++) cur[c] = '0;
      rises = 0;
      pidx  = 0;
      guard = 0;
      ph    = hub75_clk;
      pl    = hub75_lat;
      while (pidx < npass && guard < 3000) begin
         tick();
         guard++;
         if (hub75_clk && !ph) begin
            if (rises < 64) begin
               cur[rises] = {hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2};
            end
            rises++;
         end
         if (hub75_lat && !pl) begin
            cap_rises[pidx] = rises;
            for (int c = 0; c < 64; c++) cap[pidx][c] = cur[c];
            pidx++;
            rises = 0;
         end
         ph = hub75_clk;
         pl = hub75_lat;
      end
      check("capture_passes", pidx, npass);
   endtask

   initial begin
      int cyc, run, nruns, changes, badchg, bad, col, mism;
      int runs [4];
      int r_lit [4];
      int g_lit [4];
      logic [3:0]  prev_addr;
      logic [11:0] val;
      r_lit = '{0, 1, 0, 1};
      g_lit = '{1, 0, 1, 0};

      reset_n = 1'b0;
      enable  = 1'b0;
      rd_top  = '0;
      rd_bot  = '0;
      for (int i = 0; i < 1024; i++) begin
         mem_top[i] = 12'($urandom);
         mem_bot[i] = 12'($urandom);
      end

      // Reset state, then first frame with random pixels.
      repeat (3) tick();
      check("reset_outputs", int'(outs()), int'(RESET_VEC));
      reset_n = 1'b1;
      enable  = 1'b1;
      cyc = 0;
      while (!read_en && cyc < 10) begin
         tick();
         cyc++;
      end
      check("load_seen", read_en, 1);
      check("load_addr", read_addr, 0);
      check("oe_blank_at_load", hub75_oe_n, 1);
      cyc = 0;
      while (!hub75_clk && cyc < 10) begin
         tick();
         cyc++;
      end
      check("load_to_clk_rise", cyc, 2);

      run = 0;
      nruns = 0;
      changes = 0;
      badchg = 0;
      prev_addr = hub75_addr;
      for (int i = 0; i < 4; i++) runs[i] = 0;
      while (!frame_done && cyc < 11000) begin
         tick();
         cyc++;
         if (!hub75_oe_n) begin
            run++;
         end else if (run > 0) begin
            if (nruns < 4) runs[nruns] = run;
            nruns++;
            run = 0;
         end
         if (hub75_addr != prev_addr) begin
            changes++;
            if (!hub75_lat) badchg++;
         end
         prev_addr = hub75_addr;
      end
      check("frame_period", cyc, FRAME_CLKS);
      for (int i = 0; i < 4; i++) check("oe_low_len", runs[i], ON << i);
      check("oe_runs_per_frame", nruns, 64);
      check("row_addr_changes", changes, 15);
      check("addr_change_unlatched", badchg, 0);

      // Drop enable mid-frame: the frame must complete, then idle blanked.
      repeat ($urandom_range(2000, 8000)) tick();
      enable = 1'b0;
      wait_frame_done("frame_done_after_drop");
      bad = 0;
      repeat (20) begin
         tick();
         if (!hub75_oe_n || read_en || hub75_clk || hub75_lat) bad++;
      end
      check("idle_after_drop", bad, 0);
      check("idle_row_hold", hub75_addr, 15);

      // Bit-plane extraction on a fixed pattern.
      for (int i = 0; i < 1024; i++) begin
         mem_top[i] = 12'hA50;
         mem_bot[i] = 12'hFFF;
      end
      enable = 1'b1;
      capture(4);
      col = $urandom_range(0, 63);
      mism = 0;
      for (int p = 0; p < 4; p++) begin
         check("pat_r1", cap[p][col][5], r_lit[p]);
         check("pat_g1", cap[p][col][4], g_lit[p]);
         check("pat_b1", cap[p][col][3], 0);
         check("pat_rgb2", cap[p][col][2:0], 7);
         check("pat_rises", cap_rises[p], 64);
         for (int c = 0; c < 64; c++) begin
            if (cap[p][c] != {r_lit[p][0], g_lit[p][0], 1'b0, 3'b111}) mism++;
         end
      end
      check("pat_all_cols", mism, 0);
      enable = 1'b0;
      wait_frame_done("frame_done_pattern");
      repeat (3) tick();

      // Column ordering: top word carries its column index.
      for (int i = 0; i < 1024; i++) begin
         mem_top[i] = 12'(i % 64);
         mem_bot[i] = 12'($urandom);
      end
      enable = 1'b1;
      capture(4);
      mism = 0;
      for (int c = 0; c < 64; c++) begin
         for (int p = 0; p < 4; p++) begin
            val[8 + p] = cap[p][c][5];
            val[4 + p] = cap[p][c][4];
            val[p]     = cap[p][c][3];
         end
         if (int'(val) != c) mism++;
      end
      check("col_order", mism, 0);
      check("col_rises", cap_rises[0], 64);

      // Asynchronous reset while lit, then clean restart.
      cyc = 0;
      while (hub75_oe_n && cyc < 2000) begin
         tick();
         cyc++;
      end
      check("display_reached", hub75_oe_n, 0);
      repeat ($urandom_range(0, 5)) tick();
      #2 reset_n = 1'b0;
      #1 check("async_reset", int'(outs()), int'(RESET_VEC));
      repeat (3) tick();
      reset_n = 1'b1;
      cyc = 0;
      while (!read_en && cyc < 10) begin
         tick();
         cyc++;
      end
      check("restart_load", read_en, 1);
      check("restart_addr", read_addr, 0);
      cyc = 0;
      while (!hub75_lat && cyc < 300) begin
         tick();
         cyc++;
      end
      check("restart_latch_delay", cyc, 129);
      check("restart_row", hub75_addr, 0);
      repeat (1500) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
